// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// State encoding is fixed here so the controller and any debug logic agree.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must reach WIDTH-1; one spare code keeps the compare simple.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// 1-bit full subtractor cell: d = x - y - z, bo = borrow out.
// Combinational, zero latency, no flow control.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ z;
  assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin over WIDTH bits, LSB first, through one shared cell.
// Latency WIDTH+1 cycles from start to done; start is ignored while busy.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             br;
  logic [CW-1:0]    count;
  logic             cell_d, cell_bo;
  logic             load, last;

  full_sub_bit u_cell (
    .x  (sa[0]),
    .y  (sb[0]),
    .z  (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE accepts start just like IDLE so operations can run back to back.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      br         <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      sa    <= a;
      sb    <= b;
      br    <= bin;
      sd    <= '0;
      count <= '0;
    end else if (state == SHIFT) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      sd    <= {cell_d, sd[WIDTH-1:1]};
      br    <= cell_bo;
      count <= count + CW'(1);
      // Result registers only move on the final bit so they hold across later runs.
      if (last) begin
        diff       <= {cell_d, sd[WIDTH-1:1]};
        borrow_out <= cell_bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8) and its full_sub_bit cell.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow_out;

  logic cx, cy, cz, cd, cbo;

  int tests_run;
  int tests_failed;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  full_sub_bit u_cell_chk (
    .x  (cx),
    .y  (cy),
    .z  (cz),
    .d  (cd),
    .bo (cbo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  typedef struct {
    logic x, y, z;
    logic d, bo;
  } cell_t;

  vec_t  vecs[7];
  cell_t cells[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a request at a negedge; returns just after the accepting posedge.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    @(negedge clk);
    a = ta;
    b = tb;
    bin = tbin;
    start = 1'b1;
    @(posedge clk);
  endtask

  // n = negedges seen after the accept edge up to and including the done one.
  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  initial begin
    int n, bcnt;
    logic seen;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};

    cells[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cells[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cells[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cells[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cells[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cells[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    cells[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cells[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    cx = 1'b0;
    cy = 1'b0;
    cz = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cx = cells[i].x;
      cy = cells[i].y;
      cz = cells[i].z;
      #1;
      check($sformatf("cell%0d_d", i), 32'(cd), 32'(cells[i].d));
      check($sformatf("cell%0d_bo", i), 32'(cbo), 32'(cells[i].bo));
    end

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bo", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done(n, bcnt);
      check($sformatf("v%0d_latency", i), 32'(n), 32'd9);
      check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd8);
      check($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].d));
      check($sformatf("v%0d_bo", i), 32'(borrow_out), 32'(vecs[i].bo));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'({busy, done}), 32'd0);
    end

    // Start pulsed during the third busy cycle must be ignored.
    launch(8'h35, 8'h12, 1'b0);
    n = 0;
    bcnt = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      start = (n == 3);
      if (n == 3) begin
        a = 8'hFF;
        b = 8'h01;
        bin = 1'b1;
      end
      if (busy) bcnt++;
      if (done) break;
    end
    check("ign_latency", 32'(n), 32'd9);
    check("ign_busy_cycles", 32'(bcnt), 32'd8);
    check("ign_diff", 32'(diff), 32'h23);
    check("ign_bo", 32'(borrow_out), 32'd0);

    // Start held during DONE starts the next op with no idle cycle.
    launch(8'h12, 8'h35, 1'b0);
    wait_done(n, bcnt);
    check("b2b_first_diff", 32'(diff), 32'hDD);
    a = 8'h10;
    b = 8'h0F;
    bin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap", 32'({busy, done}), 32'b10);
    repeat (3) @(negedge clk);
    check("b2b_diff_held", 32'({borrow_out, diff}), 32'h1DD);
    wait_done(n, bcnt);
    check("b2b_latency", 32'(n), 32'd5);
    check("b2b_diff", 32'(diff), 32'h00);
    check("b2b_bo", 32'(borrow_out), 32'd0);

    // Reset during the fourth busy cycle aborts with no done pulse.
    launch(8'h00, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bo", 32'(borrow_out), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    launch(8'h80, 8'h7F, 1'b0);
    wait_done(n, bcnt);
    check("post_rst_latency", 32'(n), 32'd9);
    check("post_rst_diff", 32'(diff), 32'h01);
    check("post_rst_bo", 32'(borrow_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. It sequences a single 1-bit full-subtractor cell over a WIDTH-bit operand pair, LSB first, and holds the borrow between cycles in a register. A start/busy/done handshake lets a host launch one subtraction at a time. It produces diff = a - b - bin mod 2^WIDTH and the final borrow.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request, sampled on rising edge
a  input  WIDTH  minuend, captured when start is accepted
b  input  WIDTH  subtrahend, captured when start is accepted
bin  input  1  initial borrow-in, captured when start is accepted
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  result, held stable from done until the next accepted start
borrow_out  output  1  final borrow (1 when a < b + bin unsigned), held with diff

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, diff=0, borrow_out=0, count=0; shift and borrow registers cleared.
- FSM states: IDLE, SHIFT, DONE. Encoding is taken from the package.
- IDLE: if start=1 at edge k, then:
  - load sa<=a, sb<=b, br<=bin, sd<=0, count<=0;
  - go to SHIFT.
- SHIFT, each edge:
  - cell inputs x=sa[0], y=sb[0], z=br;
  - d = x^y^z; bnext = (~x&y) | (~(x^y)&z);
  - sa, sb shift right by 1; sd <= {d, sd[WIDTH-1:1]}; br<=bnext; count<=count+1;
  - when count==WIDTH-1 at the edge: write diff<={d, sd[WIDTH-1:1]} and borrow_out<=bnext, then go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. A start=1 in DONE is accepted exactly as in IDLE (load, go to SHIFT), which allows back-to-back operation.
- Output decode: busy = (state==SHIFT); done = (state==DONE).
- Latency: start accepted at edge k; WIDTH shift edges k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH. The next start can be accepted at edge k+WIDTH+1.
- start while busy: ignored. Operands, bin and count are unaffected.
- diff/borrow_out change only at the final SHIFT edge; they are not disturbed during a later operation until that operation's final edge.
- Operand inputs a/b/bin may change freely after acceptance.
- Counter width: $clog2(WIDTH+1). No wrap is possible because the counter is cleared at each load.
- Reset mid-operation aborts immediately to reset values. There is no done pulse for the aborted operation.
- No X propagation: every register has a reset value.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - function for counter width.
- One sub-module, full_sub_bit (purely combinational):
  - inputs x, y, z; outputs d, bo;
  - instantiated once as the shared datapath cell.
- The controller owns all registers and the FSM.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h12, bin=0, start 1 cycle -> busy high 8 cycles, done pulse 9 edges after start edge, diff=8'h23, borrow_out=0.
- a=8'h12, b=8'h35, bin=0 -> diff=8'hDD, borrow_out=1.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, borrow_out=1. Then a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, borrow_out=0.
- Exhaustive 1-bit cell check through full_sub_bit: all 8 {x,y,z} combos -> d/bo match the truth table (e.g. 0,1,1 -> d=0, bo=1).
- Start pulsed again at 3rd busy cycle with different operands -> ignored; result equals the first operation's. Start held during DONE -> new operation begins with no idle gap.
- rst_n dropped at 4th busy cycle -> busy, done, diff, borrow_out all 0 asynchronously; no done pulse. A subsequent start runs correctly.
